// File: rtl/cdc_hk_rx_mux.sv
// Read-domain side of a multi-channel toggle-flag CDC handshake: synchronises per-channel
// request toggles, returns ack toggles, and merges payloads round-robin into one valid/ready stream.
module cdc_hk_rx_mux #(
  parameter  int NUM_CH      = 4,
  parameter  int DATA_W      = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       rclk,
  input  logic                       rd_rst_n,
  input  logic [NUM_CH-1:0]          wr_req_tgl,
  input  logic [NUM_CH*DATA_W-1:0]   wr_data,
  output logic [NUM_CH-1:0]          rd_ack_tgl,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [DATA_W-1:0]          rd_data,
  output logic [CH_W-1:0]            rd_ch,
  output logic [NUM_CH-1:0]          ch_pending
);

  logic [NUM_CH-1:0] w_req_s;
  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] r_ack;
  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_last_grant;

  logic              w_free;
  logic              w_grant_vld;
  logic [CH_W-1:0]   w_grant_ch;
  int                w_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      always_ff @(posedge rclk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], wr_req_tgl[gi]};
        end
      end

      assign w_req_s[gi] = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_pending = w_req_s ^ r_ack;
  assign w_free    = !r_vld || rd_rdy;

  // Search starts one past the last grant so every channel gets a turn.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    w_idx       = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = (int'(r_last_grant) + i) % NUM_CH;
      if (w_free && !w_grant_vld && w_pending[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = CH_W'(w_idx);
      end
    end
  end

  // Ack toggles at load time: the payload is captured, so the sender may move on.
  always_ff @(posedge rclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_ack        <= '0;
      r_vld        <= 1'b0;
      r_data       <= '0;
      r_ch         <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else if (w_grant_vld) begin
      r_data              <= wr_data[int'(w_grant_ch) * DATA_W +: DATA_W];
      r_ch                <= w_grant_ch;
      r_vld               <= 1'b1;
      r_ack[w_grant_ch]   <= ~r_ack[w_grant_ch];
      r_last_grant        <= w_grant_ch;
    end else if (rd_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign rd_ack_tgl = r_ack;
  assign rd_vld     = r_vld;
  assign rd_data    = r_data;
  assign rd_ch      = r_ch;
  assign ch_pending = w_pending;

endmodule

// File: tb/tb_cdc_hk_rx_mux.sv
// Bench for cdc_hk_rx_mux: table-driven single transfers plus hand-written round-robin,
// backpressure, pipelined-sender and mid-operation reset sequences, with an output scoreboard.
module tb_cdc_hk_rx_mux;

  logic        rclk;
  logic        rd_rst_n;
  logic [3:0]  wr_req_tgl;
  logic [31:0] wr_data;
  logic [3:0]  rd_ack_tgl;
  logic        rd_vld;
  logic        rd_rdy;
  logic [7:0]  rd_data;
  logic [1:0]  rd_ch;
  logic [3:0]  ch_pending;

  cdc_hk_rx_mux #(.NUM_CH(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .rclk       (rclk),
    .rd_rst_n   (rd_rst_n),
    .wr_req_tgl (wr_req_tgl),
    .wr_data    (wr_data),
    .rd_ack_tgl (rd_ack_tgl),
    .rd_vld     (rd_vld),
    .rd_rdy     (rd_rdy),
    .rd_data    (rd_data),
    .rd_ch      (rd_ch),
    .ch_pending (ch_pending)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       exp_ack;
  } vec_t;

  sb_t        exp_q[$];
  logic [1:0] obs_ch   [256];
  logic [7:0] obs_data [256];
  int         obs_wr = 0;
  int         obs_rd = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  vec_t       vecs[6];

  // Every completed handshake (vld && rdy at the coming edge) is logged here.
  always @(negedge rclk) begin
    if (rd_rst_n && rd_vld && rd_rdy && obs_wr < 256) begin
      obs_ch[obs_wr]   <= rd_ch;
      obs_data[obs_wr] <= rd_data;
      obs_wr           <= obs_wr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic send(input int ch, input logic [7:0] d);
    sb_t e;
    wr_data[ch*8 +: 8] = d;
    wr_req_tgl[ch]     = ~wr_req_tgl[ch];
    e.ch   = 2'(ch);
    e.data = d;
    exp_q.push_back(e);
    $display("send ch=%0d data=0x%02h", ch, d);
  endtask

  task automatic drain();
    sb_t e;
    while (obs_rd < obs_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra_word: got ch=%0d data=0x%02h, expected no word",
                 obs_ch[obs_rd], obs_data[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        check("sb_ch", {30'b0, obs_ch[obs_rd]}, {30'b0, e.ch});
        check("sb_data", {24'b0, obs_data[obs_rd]}, {24'b0, e.data});
        $display("recv ch=%0d data=0x%02h", obs_ch[obs_rd], obs_data[obs_rd]);
      end
      obs_rd++;
    end
  endtask

  initial begin
    int start;
    int cnt;
    bit done;

    // Last row is channel 3 so the round-robin burst afterwards starts at channel 0.
    vecs[0] = '{ch: 2, data: 8'hA5, exp_ack: 1'b1};
    vecs[1] = '{ch: 0, data: 8'h3C, exp_ack: 1'b1};
    vecs[2] = '{ch: 1, data: 8'h81, exp_ack: 1'b1};
    vecs[3] = '{ch: 2, data: 8'h00, exp_ack: 1'b0};
    vecs[4] = '{ch: 0, data: 8'h7E, exp_ack: 1'b0};
    vecs[5] = '{ch: 3, data: 8'hFF, exp_ack: 1'b1};

    rd_rst_n   = 1'b0;
    wr_req_tgl = '0;
    wr_data    = '0;
    rd_rdy     = 1'b1;
    repeat (3) tick();
    check("rst_vld", {31'b0, rd_vld}, 0);
    check("rst_ack", {28'b0, rd_ack_tgl}, 0);
    check("rst_ch", {30'b0, rd_ch}, 0);
    check("rst_data", {24'b0, rd_data}, 0);
    rd_rst_n = 1'b1;
    repeat (20) begin
      tick();
      check("idle_vld", {31'b0, rd_vld}, 0);
    end

    // Single transfers: latency of SYNC_STAGES+1 edges, ack toggles with the load.
    for (int r = 0; r < 6; r++) begin
      send(vecs[r].ch, vecs[r].data);
      tick(); check("lat_e1_vld", {31'b0, rd_vld}, 0);
      tick(); check("lat_e2_vld", {31'b0, rd_vld}, 0);
      tick();
      check("lat_e3_vld", {31'b0, rd_vld}, 1);
      check("lat_e3_ch", {30'b0, rd_ch}, vecs[r].ch);
      check("lat_e3_data", {24'b0, rd_data}, {24'b0, vecs[r].data});
      check("lat_e3_ack", {31'b0, rd_ack_tgl[vecs[r].ch]}, {31'b0, vecs[r].exp_ack});
      tick(); check("lat_e4_vld", {31'b0, rd_vld}, 0);
      drain();
    end

    // Round robin: all four at once, served 0,1,2,3 on consecutive edges.
    for (int c = 0; c < 4; c++) send(c, 8'(8'h10 + c));
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rr_vld", {31'b0, rd_vld}, 1);
      check("rr_ch", {30'b0, rd_ch}, c);
      check("rr_data", {24'b0, rd_data}, 32'h10 + c);
    end
    check("rr_pending_clear", {28'b0, ch_pending}, 0);
    tick(); check("rr_idle_vld", {31'b0, rd_vld}, 0);
    drain();

    // Backpressure: ch1 loads and holds, ch3 waits without an ack toggle.
    rd_rdy = 1'b0;
    send(1, 8'h21);
    send(3, 8'h43);
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_vld", {31'b0, rd_vld}, 1);
      check("bp_ch", {30'b0, rd_ch}, 1);
      check("bp_data", {24'b0, rd_data}, 32'h21);
      check("bp_ack1", {31'b0, rd_ack_tgl[1]}, {31'b0, wr_req_tgl[1]});
      check("bp_ack3_held", {31'b0, rd_ack_tgl[3]}, {31'b0, !wr_req_tgl[3]});
      check("bp_pending", {28'b0, ch_pending}, 32'b1000);
      if (k < 4) tick();
    end
    rd_rdy = 1'b1;
    tick();
    check("bp_ch3_vld", {31'b0, rd_vld}, 1);
    check("bp_ch3_ch", {30'b0, rd_ch}, 3);
    check("bp_ch3_data", {24'b0, rd_data}, 32'h43);
    check("bp_ch3_ack", {31'b0, rd_ack_tgl[3]}, {31'b0, wr_req_tgl[3]});
    check("bp_pending_clear", {28'b0, ch_pending}, 0);
    tick(); check("bp_idle_vld", {31'b0, rd_vld}, 0);
    drain();

    // Pipelined sender on ch0 with a randomly stalling consumer.
    start = obs_wr;
    done  = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(0, 8'(k));
          cnt = 0;
          do begin
            tick();
            cnt++;
          end while (rd_ack_tgl[0] != wr_req_tgl[0] && cnt < 50);
          check("pipe_ack_seen", {31'b0, rd_ack_tgl[0]}, {31'b0, wr_req_tgl[0]});
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rd_rdy = 1'($urandom_range(0, 1));
          tick();
        end
        rd_rdy = 1'b1;
      end
    join
    cnt = 0;
    while (obs_wr - start < 8 && cnt < 50) begin
      tick();
      cnt++;
    end
    tick(); tick();
    check("pipe_count", obs_wr - start, 8);
    drain();

    // Mid-operation reset while a word is stalled in the output register.
    rd_rdy = 1'b0;
    send(2, 8'h5A);
    tick(); tick(); tick();
    check("mr_pre_vld", {31'b0, rd_vld}, 1);
    check("mr_pre_ch", {30'b0, rd_ch}, 2);
    check("mr_pre_data", {24'b0, rd_data}, 32'h5A);
    tick();
    #2;
    rd_rst_n   = 1'b0;
    wr_req_tgl = '0;
    #1;
    check("mr_async_vld", {31'b0, rd_vld}, 0);
    check("mr_async_ack", {28'b0, rd_ack_tgl}, 0);
    check("mr_async_ch", {30'b0, rd_ch}, 0);
    check("mr_async_data", {24'b0, rd_data}, 0);
    exp_q.delete();
    repeat (2) begin
      tick();
      check("mr_hold_vld", {31'b0, rd_vld}, 0);
    end
    rd_rst_n = 1'b1;
    rd_rdy   = 1'b1;
    wr_data  = '0;
    repeat (3) begin
      tick();
      check("mr_post_idle_vld", {31'b0, rd_vld}, 0);
    end
    send(1, 8'hC3);
    tick(); tick(); tick();
    check("mr_fresh_vld", {31'b0, rd_vld}, 1);
    check("mr_fresh_ch", {30'b0, rd_ch}, 1);
    check("mr_fresh_data", {24'b0, rd_data}, 32'hC3);
    check("mr_fresh_ack", {31'b0, rd_ack_tgl[1]}, 1);
    tick(); check("mr_fresh_idle_vld", {31'b0, rd_vld}, 0);
    drain();

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
